// File: rtl/frog_turn_sequencer.sv
// rtl/frog_turn_sequencer.sv - per-frame turn scheduler for three frogs: spawn, home slots, death events, turn timer
// Optional turn-timeout deaths are enabled by defining TURN_TIMEOUT_EN.
module frog_turn_sequencer #(
    parameter int HOME_Y         = 40,
    parameter int SLOT0_X        = 120,
    parameter int SLOT1_X        = 280,
    parameter int SLOT2_X        = 480,
    parameter int TURN_FRAMES    = 1800,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic        frame_clk,
    input  logic        game_restart_n,
    input  logic [10:0] frog1_x,
    input  logic [10:0] frog2_x,
    input  logic [10:0] frog3_x,
    input  logic [10:0] frog1_y,
    input  logic [10:0] frog2_y,
    input  logic [10:0] frog3_y,
    input  logic        collision_hit,
    input  logic        game_over,
    output logic [1:0]  active_frog,
    output logic        spawn_pulse,
    output logic        dead_frog,
    output logic [2:0]  slot_filled,
    output logic        all_home,
    output logic [10:0] turn_timer
);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_PLAY, S_DYING, S_HOME, S_WAIT, S_DONE
    } state_t;

    localparam logic [10:0] HOME_Y_W     = 11'(HOME_Y);
    localparam logic [10:0] SLOT0_W      = 11'(SLOT0_X);
    localparam logic [10:0] SLOT1_W      = 11'(SLOT1_X);
    localparam logic [10:0] SLOT2_W      = 11'(SLOT2_X);
    localparam logic [10:0] TURN_W       = 11'(TURN_FRAMES);
    localparam logic [10:0] RESPAWN_LAST = 11'(RESPAWN_FRAMES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  active_d;
    logic        spawn_d, dead_d, all_home_d;
    logic [2:0]  slot_d;
    logic [10:0] timer_d;

    logic [10:0] cur_x, cur_y;
    logic [2:0]  slot_hit;
    logic        at_home_row, empty_hit;

    always_comb begin
        case (idx_q)
            2'd2:    begin cur_x = frog2_x; cur_y = frog2_y; end
            2'd3:    begin cur_x = frog3_x; cur_y = frog3_y; end
            default: begin cur_x = frog1_x; cur_y = frog1_y; end
        endcase
        slot_hit    = {cur_x == SLOT2_W, cur_x == SLOT1_W, cur_x == SLOT0_W};
        at_home_row = (cur_y == HOME_Y_W);
        empty_hit   = |(slot_hit & ~slot_filled);
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        active_d   = active_frog;
        spawn_d    = 1'b0;
        dead_d     = 1'b0;
        slot_d     = slot_filled;
        all_home_d = all_home;
        timer_d    = turn_timer;

        // game_over outranks every same-cycle event, including deaths and homes
        if (game_over) begin
            state_d  = S_DONE;
            active_d = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_SPAWN;
                    spawn_d  = 1'b1;
                    active_d = idx_q;
                    timer_d  = TURN_W;
                end
                S_SPAWN: state_d = S_PLAY;
                S_PLAY: begin
                    if (collision_hit) begin
                        state_d = S_DYING;
                        dead_d  = 1'b1;
                    end else if (at_home_row && empty_hit) begin
                        state_d = S_HOME;
                        slot_d  = slot_filled | slot_hit;
                    end else if (at_home_row) begin
                        state_d = S_DYING;
                        dead_d  = 1'b1;
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (turn_timer == 11'd0) begin
                        state_d = S_DYING;
                        dead_d  = 1'b1;
                    end else begin
                        timer_d = turn_timer - 11'd1;
                    end
`endif
                end
                S_DYING: begin
                    state_d  = S_WAIT;
                    active_d = 2'd0;
                    cnt_d    = 11'd0;
                end
                S_HOME: begin
                    active_d = 2'd0;
                    if (slot_filled == 3'b111) begin
                        all_home_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = 11'd0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == RESPAWN_LAST) begin
                        state_d  = S_SPAWN;
                        spawn_d  = 1'b1;
                        active_d = idx_q;
                        timer_d  = TURN_W;
                        cnt_d    = 11'd0;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
                S_DONE:  active_d = 2'd0;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge game_restart_n) begin
        if (!game_restart_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd1;
            cnt_q       <= 11'd0;
            active_frog <= 2'd0;
            spawn_pulse <= 1'b0;
            dead_frog   <= 1'b0;
            slot_filled <= 3'b000;
            all_home    <= 1'b0;
            turn_timer  <= TURN_W;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            active_frog <= active_d;
            spawn_pulse <= spawn_d;
            dead_frog   <= dead_d;
            slot_filled <= slot_d;
            all_home    <= all_home_d;
            turn_timer  <= timer_d;
        end
    end

endmodule

// File: tb/tb_frog_turn_sequencer.sv
// tb/tb_frog_turn_sequencer.sv - directed self-checking bench for frog_turn_sequencer
module tb_frog_turn_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] f1x, f2x, f3x, f1y, f2y, f3y;
    logic        collision, over;
    logic [1:0]  active_frog;
    logic        spawn_pulse, dead_frog, all_home;
    logic [2:0]  slot_filled;
    logic [10:0] turn_timer;

    int checks = 0;
    int errors = 0;
    logic seen;

    frog_turn_sequencer dut (
        .frame_clk      (clk),
        .game_restart_n (rst_n),
        .frog1_x        (f1x),
        .frog2_x        (f2x),
        .frog3_x        (f3x),
        .frog1_y        (f1y),
        .frog2_y        (f2y),
        .frog3_y        (f3y),
        .collision_hit  (collision),
        .game_over      (over),
        .active_frog    (active_frog),
        .spawn_pulse    (spawn_pulse),
        .dead_frog      (dead_frog),
        .slot_filled    (slot_filled),
        .all_home       (all_home),
        .turn_timer     (turn_timer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        f1x = 0; f2x = 0; f3x = 0; f1y = 0; f2y = 0; f3y = 0;
        collision = 1'b0; over = 1'b0;
        step(2);
        check("rst_active", active_frog, 0);
        check("rst_spawn", spawn_pulse, 0);
        check("rst_dead", dead_frog, 0);
        check("rst_slots", slot_filled, 0);
        check("rst_all_home", all_home, 0);
        check("rst_timer", turn_timer, 1800);

        rst_n = 1'b1;
        step(1);
        check("t1_spawn", spawn_pulse, 1);
        check("t1_active", active_frog, 1);
        check("t1_timer", turn_timer, 1800);
        step(1);
        check("t1_spawn_drop", spawn_pulse, 0);
        check("t1_active_play", active_frog, 1);

        // frog1 reaches slot 1; it then sits there while frog2 plays
        f1x = 280; f1y = 40;
        step(1);
        check("t2_slots", slot_filled, 3'b010);
        check("t2_dead", dead_frog, 0);
        step(1);
        check("t2_wait_active", active_frog, 0);
        step(59);
        check("t2_no_early_spawn", spawn_pulse, 0);
        step(1);
        check("t2_spawn", spawn_pulse, 1);
        check("t2_active", active_frog, 2);
        step(1);

        // frog2 lands on the already filled slot 1
        f2x = 280; f2y = 40;
        step(1);
        check("t3_dead", dead_frog, 1);
        check("t3_slots", slot_filled, 3'b010);
        check("t3_active", active_frog, 2);
        f2x = 0; f2y = 0;
        step(1);
        check("t3_dead_drop", dead_frog, 0);
        step(60);
        check("t3_respawn", spawn_pulse, 1);
        check("t3_respawn_active", active_frog, 2);
        step(1);

        // collision outranks an empty-slot arrival
        f2x = 120; f2y = 40; collision = 1'b1;
        step(1);
        check("t4_dead", dead_frog, 1);
        check("t4_slots", slot_filled, 3'b010);
        collision = 1'b0; f2x = 0; f2y = 0;
        step(61);
        check("t4_respawn_active", active_frog, 2);
        step(1);

        // remaining homes: frog2 to slot 0, frog3 to slot 2
        f2x = 120; f2y = 40;
        step(1);
        check("t5_slots_a", slot_filled, 3'b011);
        step(61);
        check("t5_spawn3", spawn_pulse, 1);
        check("t5_active3", active_frog, 3);
        step(1);
        f3x = 480; f3y = 40;
        step(1);
        check("t5_slots_b", slot_filled, 3'b111);
        check("t5_all_home_early", all_home, 0);
        step(1);
        check("t5_all_home", all_home, 1);
        check("t5_done_active", active_frog, 0);
        f3x = 0; f3y = 0;
        step(70);
        check("t5_hold_all_home", all_home, 1);
        check("t5_hold_spawn", spawn_pulse, 0);
        check("t5_hold_active", active_frog, 0);
        check("t5_hold_slots", slot_filled, 3'b111);

        // asynchronous reset takes effect between clock edges
        rst_n = 1'b0;
        #1;
        check("ar_slots", slot_filled, 0);
        check("ar_all_home", all_home, 0);
        check("ar_timer", turn_timer, 1800);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("ar_spawn", spawn_pulse, 1);
        check("ar_active", active_frog, 1);
        step(1);

        // game_over wins over same-cycle collision and home arrival
        f1x = 120; f1y = 40; collision = 1'b1; over = 1'b1;
        step(1);
        check("go_dead", dead_frog, 0);
        check("go_active", active_frog, 0);
        check("go_slots", slot_filled, 0);
        over = 1'b0; collision = 1'b0; f1x = 0; f1y = 0;
        step(80);
        check("go_hold_spawn", spawn_pulse, 0);
        check("go_hold_dead", dead_frog, 0);
        check("go_hold_active", active_frog, 0);

        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(2);
        check("to_play_active", active_frog, 1);
        check("to_play_timer", turn_timer, 1800);
`ifdef TURN_TIMEOUT_EN
        step(5);
        check("to_countdown", turn_timer, 1795);
        step(1795);
        check("to_timer_zero", turn_timer, 0);
        check("to_not_dead_yet", dead_frog, 0);
        step(1);
        check("to_dead", dead_frog, 1);
        step(1);
        check("to_dead_drop", dead_frog, 0);
`else
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (dead_frog) seen = 1'b1;
        end
        check("nto_no_death", seen, 0);
        check("nto_timer_held", turn_timer, 1800);
        check("nto_active", active_frog, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
